// File: rtl/sfx_scheduler.sv
// -----------------------------------------------------------------------------
// sfx_scheduler
//
// Shares the single speaker tone generator between the background-music
// sequencer and N_REQ sound-effect requesters. A granted effect plays for
// max(dur,1) duration ticks. It is followed by GAP_TICKS silent ticks for
// articulation. When no effect is running, the music note passes through.
//
// Build option:
//   SFX_ROUND_ROBIN_EN  defined   -> round-robin arbitration. The search
//                                    starts at the last winner + 1.
//                       undefined -> fixed priority. The lowest index wins.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sfx_req_i     level request per requester, held until ack
//   sfx_note_i    note for requester i at [6i+5:6i], sampled at grant
//   sfx_dur_i     duration in ticks for requester i, sampled at grant
//   sfx_ack_o     one-cycle grant pulse (one-hot)
//   sfx_done_o    one-cycle end-of-effect pulse (one-hot)
//   music_note_i  background note from the sequencer
//   music_en_i    1 = music audible while idle
//   fullnote_o    registered note to the tone generator (0 = rest)
//   sfx_active_o  high while an effect or its gap is in progress
// -----------------------------------------------------------------------------
module sfx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int TICK_DIV  = 250000,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       sfx_req_i,
    input  logic [6*N_REQ-1:0]     sfx_note_i,
    input  logic [DUR_W*N_REQ-1:0] sfx_dur_i,
    output logic [N_REQ-1:0]       sfx_ack_o,
    output logic [N_REQ-1:0]       sfx_done_o,
    input  logic [5:0]             music_note_i,
    input  logic                   music_en_i,
    output logic [5:0]             fullnote_o,
    output logic                   sfx_active_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    // One counter serves both the effect duration and the silent gap.
    localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } state_t;

    state_t               state_q;
    logic [PS_W-1:0]      ps_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     owner_q;
    logic [5:0]           fullnote_q;
    logic [N_REQ-1:0]     ack_q;
    logic [N_REQ-1:0]     done_q;
    logic                 active_q;

    logic [5:0]           note_arr [N_REQ];
    logic [DUR_W-1:0]     dur_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign note_arr[gi] = sfx_note_i[6*gi +: 6];
            assign dur_arr[gi]  = sfx_dur_i[DUR_W*gi +: DUR_W];
        end
    endgenerate

    logic             tick;
    logic [5:0]       music_sel;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic [CNT_W-1:0] dur_load;

    assign tick      = (ps_q == PS_W'(TICK_DIV - 1));
    assign music_sel = music_en_i ? music_note_i : 6'd0;
    // A zero duration still plays one full tick.
    assign dur_load  = (dur_arr[grant_idx] == '0) ? CNT_W'(1) : CNT_W'(dur_arr[grant_idx]);

`ifdef SFX_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(rr_ptr_q) + 1 + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_vld && sfx_req_i[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end
`else
    always_comb begin
        logic [IDX_W-1:0] k_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        k_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            k_idx = IDX_W'(k);
            if (!grant_vld && sfx_req_i[k_idx]) begin
                grant_vld = 1'b1;
                grant_idx = k_idx;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ps_q       <= '0;
            cnt_q      <= '0;
            owner_q    <= '0;
            fullnote_q <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            active_q   <= 1'b0;
`ifdef SFX_ROUND_ROBIN_EN
            // Start at the last requester so that requester 0 wins first.
            rr_ptr_q   <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            ps_q   <= tick ? '0 : ps_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    fullnote_q <= music_sel;
                    if (grant_vld) begin
                        state_q            <= ST_PLAY;
                        ps_q               <= '0;
                        cnt_q              <= dur_load;
                        owner_q            <= grant_idx;
                        fullnote_q         <= note_arr[grant_idx];
                        ack_q[grant_idx]   <= 1'b1;
                        active_q           <= 1'b1;
`ifdef SFX_ROUND_ROBIN_EN
                        rr_ptr_q           <= grant_idx;
`endif
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            done_q[owner_q] <= 1'b1;
                            if (GAP_TICKS == 0) begin
                                state_q    <= ST_IDLE;
                                fullnote_q <= music_sel;
                                active_q   <= 1'b0;
                            end else begin
                                state_q    <= ST_GAP;
                                fullnote_q <= '0;
                                cnt_q      <= CNT_W'(GAP_TICKS);
                                ps_q       <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            // Music returns in the same edge that leaves the gap.
                            state_q    <= ST_IDLE;
                            fullnote_q <= music_sel;
                            active_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sfx_ack_o    = ack_q;
    assign sfx_done_o   = done_q;
    assign fullnote_o   = fullnote_q;
    assign sfx_active_o = active_q;

endmodule
